// File: rtl/round_key_store.sv
// Round key store for an AES-256 key schedule: in-order loading from the key
// expander, zeroize on rekey, and one-cycle registered reads by round index.
module round_key_store #(
  parameter int NUM_KEYS = 15,
  parameter int KEY_W    = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             rk_in_valid,
  input  logic [KEY_W-1:0] rk_in,
  output logic             rk_in_ready,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid,
  output logic             rd_err,
  output logic             keys_ready,
  output logic [3:0]       load_count
);

  localparam logic [3:0] FULL_COUNT = 4'(NUM_KEYS);

  logic [KEY_W-1:0] entry [NUM_KEYS];
  logic             wr_fire;
  logic             rd_ok;
  logic [KEY_W-1:0] rd_mux;

  // key_start blocks the handshake so a rekey never admits a stale key
  assign rk_in_ready = (load_count < FULL_COUNT) && !key_start;
  assign wr_fire     = rk_in_valid && rk_in_ready;
  // Only already-loaded entries are readable; the one being written is not
  assign rd_ok       = rd_en && !key_start && (rd_idx < load_count);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rd_idx == 4'(i)) rd_mux = entry[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || key_start) begin
      load_count <= '0;
      keys_ready <= 1'b0;
    end else if (wr_fire) begin
      load_count <= load_count + 4'd1;
      keys_ready <= (load_count + 4'd1) == FULL_COUNT;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rst || key_start) begin
        entry[i] <= '0;
      end else if (wr_fire && load_count == 4'(i)) begin
        entry[i] <= rk_in;
      end
    end
  end

  // Read output register: the bus carries zero unless a read was accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key   <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_key   <= rd_ok ? rd_mux : '0;
      rd_valid <= rd_ok;
      rd_err   <= rd_en && !rd_ok;
    end
  end

endmodule

// File: tb/tb_round_key_store.sv
// Scoreboard bench for round_key_store: directed sequences plus randomized
// load/read/rekey traffic checked against an array-based reference model.
module tb_round_key_store;

  localparam int NK = 15;
  localparam int KW = 128;

  logic          clk = 1'b0;
  logic          rst, key_start, rk_in_valid, rd_en;
  logic [KW-1:0] rk_in;
  logic [3:0]    rd_idx;
  logic          rk_in_ready, rd_valid, rd_err, keys_ready;
  logic [KW-1:0] rd_key;
  logic [3:0]    load_count;

  always #5 clk = ~clk;

  round_key_store #(.NUM_KEYS(NK), .KEY_W(KW)) dut (
    .clk(clk), .rst(rst), .key_start(key_start),
    .rk_in_valid(rk_in_valid), .rk_in(rk_in), .rk_in_ready(rk_in_ready),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_key(rd_key),
    .rd_valid(rd_valid), .rd_err(rd_err),
    .keys_ready(keys_ready), .load_count(load_count)
  );

  typedef struct {
    logic          ok;
    logic [KW-1:0] key;
  } exp_t;

  exp_t          sb[$];
  logic [KW-1:0] mkeys [NK];
  int            mcount;
  int            n_checks = 0;
  int            n_errors = 0;
  bit            done = 1'b0;

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {{(KW-1){1'b0}}, act}, {{(KW-1){1'b0}}, exp});
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mcount = 0;
    foreach (mkeys[i]) mkeys[i] = '0;
  endtask

  function automatic logic [KW-1:0] rnd_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: drive inputs, predict with the model, then check state.
  task automatic step(input logic r, input logic ks, input logic v,
                      input logic [KW-1:0] din, input logic re, input logic [3:0] idx);
    exp_t e;
    rst = r; key_start = ks; rk_in_valid = v; rk_in = din; rd_en = re; rd_idx = idx;
    #1;
    if (r) begin
      model_clear();
    end else begin
      chk1("rk_in_ready", rk_in_ready, (mcount < NK) && !ks);
      if (re) begin
        e.ok  = !ks && (int'(idx) < mcount);
        e.key = '0;
        if (e.ok) e.key = mkeys[idx];
        sb.push_back(e);
      end
      if (ks) begin
        model_clear();
      end else if (v && mcount < NK) begin
        mkeys[mcount] = din;
        mcount++;
      end
    end
    @(posedge clk);
    #1;
    chk_int("load_count", int'(load_count), mcount);
    chk1("keys_ready", keys_ready, mcount == NK);
    if (r) begin
      chk1("rst_rd_valid", rd_valid, 1'b0);
      chk1("rst_rd_err", rd_err, 1'b0);
      chk("rst_rd_key", rd_key, '0);
    end
  endtask

  // Monitor: every DUT read response is matched against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!done) begin
      if (rd_valid || rd_err) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got valid=%b err=%b expected no response", rd_valid, rd_err);
        end else begin
          e = sb.pop_front();
          chk1("rd_valid", rd_valid, e.ok);
          chk1("rd_err", rd_err, !e.ok);
          chk("rd_key", rd_key, e.key);
        end
      end else begin
        chk("rd_key_idle", rd_key, '0);
      end
    end
  end

  initial begin
    logic       r, ks, v, re;
    logic [3:0] idx;
    model_clear();
    step(1, 0, 0, '0, 0, 4'd0);
    step(1, 0, 0, '0, 1, 4'd0);

    // Full load with continuous valid, then back-to-back readback
    for (int i = 0; i < NK; i++) step(0, 0, 1, KW'(i), 0, 4'd0);
    for (int i = 0; i < NK; i++) step(0, 0, 0, '0, 1, 4'(i));

    // Full store holds off further keys; entry 14 must survive
    for (int i = 0; i < 3; i++) step(0, 0, 1, KW'(128'hDEAD), 1, 4'd14);

    // Rekey collides with a write and a read
    step(0, 1, 1, rnd_key(), 1, 4'd0);
    step(0, 0, 0, '0, 1, 4'd0);

    // Partial load, legal and illegal reads
    for (int i = 0; i < 3; i++) step(0, 0, 1, rnd_key(), 0, 4'd0);
    step(0, 0, 0, '0, 1, 4'd2);
    step(0, 0, 0, '0, 1, 4'd3);
    step(0, 0, 0, '0, 1, 4'd15);
    step(0, 0, 1, rnd_key(), 1, 4'd3);
    step(0, 0, 0, '0, 1, 4'd1);

    // Reset mid-load, then reload from index 0
    for (int i = 0; i < 3; i++) step(0, 0, 1, rnd_key(), 0, 4'd0);
    step(1, 0, 1, rnd_key(), 1, 4'd2);
    step(0, 0, 1, rnd_key(), 1, 4'd0);
    step(0, 0, 1, rnd_key(), 1, 4'd0);
    step(0, 0, 0, '0, 1, 4'd1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      ks = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 2) != 0);
      re = ($urandom_range(0, 1) == 1);
      if (mcount > 0 && $urandom_range(0, 3) != 0) idx = 4'($urandom_range(0, mcount - 1));
      else idx = 4'($urandom_range(0, 15));
      step(r, ks, v, rnd_key(), re, idx);
    end

    step(0, 0, 0, '0, 0, 4'd0);
    step(0, 0, 0, '0, 0, 4'd0);
    done = 1'b1;
    chk_int("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
